hd_power_accum: RTL and testbench

- Downstream observation stage for the key-masked 2-bit adder datapath.
- Samples the adder's 3-bit sum bus over a window of WIN transfers and accumulates a Hamming-distance (toggle) power estimate and a Hamming-weight estimate.
- Reports one result per window over a valid/ready handshake to the trace collector.
- Gives the power side-channel flow a synthesizable, cycle-exact leakage proxy to replace offline VCD post-processing.

---
 rtl/hd_power_pkg.sv | 11 +
 rtl/hd_power_accum_if.sv | 25 ++
 rtl/hd_popcount.sv | 14 +
 rtl/hd_power_accum.sv | 95 +++++++++
 tb/tb_hd_power_accum.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hd_power_pkg.sv
// hd_power_pkg: shared FSM state type, default sizing constants and peak-width helper
// Used by hd_power_accum_if, hd_power_accum and the bench.
package hd_power_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, ACCUM, REPORT} state_t;
    localparam int DW_DEF   = 3;
    localparam int WIN_DEF  = 16;
    localparam int ACCW_DEF = 8;
    function automatic int peak_w(input int dw);
        return $clog2(dw + 1);
    endfunction
endpackage

// File: rtl/hd_power_accum_if.sv
// hd_power_accum_if: sample stream in, window result out, both valid/ready
// Signals: in_valid/in_data/in_ready (sample side), out_valid/out_ready/out_hd_sum/out_hw_sum/out_hd_peak (result side).
// Modports: slave = the accumulator block, master = the producer/consumer around it.
interface hd_power_accum_if import hd_power_pkg::*; #(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int PW   = peak_w(DW)
) ();
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_hd_sum;
    logic [ACCW-1:0] out_hw_sum;
    logic [PW-1:0]   out_hd_peak;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_hd_sum, out_hw_sum, out_hd_peak
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_hd_sum, out_hw_sum, out_hd_peak
    );
endinterface

// File: rtl/hd_popcount.sv
// hd_popcount: combinational population count of a DW-bit word
// Ports: d (DW-bit input word), cnt (number of set bits, clog2(DW+1) wide).
module hd_popcount import hd_power_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int CW = peak_w(DW)
) (
    input  logic [DW-1:0] d,
    output logic [CW-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DW; i++) cnt = cnt + CW'(d[i]);
    end
endmodule

// File: rtl/hd_power_accum.sv
// hd_power_accum: windowed Hamming-distance / Hamming-weight power proxy of the adder sum bus
// Ports: clk, rst_n (async active-low), start, abort, busy, bus (hd_power_accum_if.slave).
// Optional macro HD_POWER_PEAK_EN adds a max-HD peak register; otherwise out_hd_peak is tied to 0.
// The accumulators double as the result registers: they only move on ACCUM accepts,
// so they hold through REPORT and IDLE until the next start or abort clears them.
module hd_power_accum import hd_power_pkg::*; #(
    parameter int DW   = DW_DEF,
    parameter int WIN  = WIN_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    hd_power_accum_if.slave bus
);
    localparam int PW = peak_w(DW);
    localparam logic [7:0] LAST = 8'(WIN - 1);

    state_t          state, state_nx;
    logic [DW-1:0]   prev;
    logic [7:0]      cnt;
    logic [ACCW-1:0] hd_acc, hw_acc;
    logic [PW-1:0]   hd, hw;
    logic            accept, acc_ok, clr;

    hd_popcount #(.DW(DW), .CW(PW)) u_hd (.d(bus.in_data ^ prev), .cnt(hd));
    hd_popcount #(.DW(DW), .CW(PW)) u_hw (.d(bus.in_data), .cnt(hw));

    function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a, input logic [PW-1:0] b);
        logic [ACCW:0] s;
        s = {1'b0, a} + (ACCW+1)'(b);
        return s[ACCW] ? '1 : s[ACCW-1:0];
    endfunction

    assign bus.in_ready  = state == PRIME || state == ACCUM;
    assign bus.out_valid = state == REPORT;
    assign busy          = state != IDLE;
    assign accept        = bus.in_valid && bus.in_ready;
    assign acc_ok        = accept && state == ACCUM;
    assign clr           = abort || (state == IDLE && start);
    assign bus.out_hd_sum = hd_acc;
    assign bus.out_hw_sum = hw_acc;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? PRIME : IDLE;
            PRIME:   state_nx = accept ? ACCUM : PRIME;
            ACCUM:   state_nx = (acc_ok && cnt == LAST) ? REPORT : ACCUM;
            REPORT:  state_nx = bus.out_ready ? IDLE : REPORT;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= '0;
            cnt    <= '0;
            hd_acc <= '0;
            hw_acc <= '0;
        end else if (clr) begin
            prev   <= '0;
            cnt    <= '0;
            hd_acc <= '0;
            hw_acc <= '0;
        end else if (accept) begin
            prev <= bus.in_data;
            if (acc_ok) begin
                cnt    <= cnt + 8'd1;
                hd_acc <= sat_add(hd_acc, hd);
                hw_acc <= sat_add(hw_acc, hw);
            end
        end
    end

`ifdef HD_POWER_PEAK_EN
    logic [PW-1:0] peak;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) peak <= '0;
        else if (clr) peak <= '0;
        else if (acc_ok && hd > peak) peak <= hd;
    end
    assign bus.out_hd_peak = peak;
`else
    assign bus.out_hd_peak = '0;
`endif
endmodule

// File: tb/tb_hd_power_accum.sv
// tb_hd_power_accum: directed bench driving two instances (ACCW=8 and ACCW=3, both WIN=4) in lockstep
module tb_hd_power_accum;
    import hd_power_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy0, busy1;
    int total = 0;
    int bad = 0;

    hd_power_accum_if #(.DW(3), .ACCW(8)) b0 ();
    hd_power_accum_if #(.DW(3), .ACCW(3)) b1 ();

    assign b1.in_valid  = b0.in_valid;
    assign b1.in_data   = b0.in_data;
    assign b1.out_ready = b0.out_ready;

    hd_power_accum #(.DW(3), .WIN(4), .ACCW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy0), .bus(b0.slave)
    );
    hd_power_accum #(.DW(3), .WIN(4), .ACCW(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy1), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int p);
`ifdef HD_POWER_PEAK_EN
        return p;
`else
        return 0 * p;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic go;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic hs;
        b0.out_ready = 1'b1;
        step;
        b0.out_ready = 1'b0;
    endtask

    task automatic send(input logic [2:0] d);
        b0.in_valid = 1'b1;
        b0.in_data  = d;
        for (int n = 0; n < 20 && !b0.in_ready; n++) step;
        if (!b0.in_ready) chk("ready_wait", 32'(b0.in_ready), 1);
        step;
        b0.in_valid = 1'b0;
    endtask

    task automatic res(input string tag, input int hd0, input int hw0, input int hd1, input int hw1, input int p);
        chk({tag, ".hd0"}, 32'(b0.out_hd_sum), hd0);
        chk({tag, ".hw0"}, 32'(b0.out_hw_sum), hw0);
        chk({tag, ".hd1"}, 32'(b1.out_hd_sum), hd1);
        chk({tag, ".hw1"}, 32'(b1.out_hw_sum), hw1);
        chk({tag, ".pk0"}, 32'(b0.out_hd_peak), p);
        chk({tag, ".pk1"}, 32'(b1.out_hd_peak), p);
    endtask

    initial begin
        b0.in_valid  = 1'b0;
        b0.in_data   = '0;
        b0.out_ready = 1'b0;
        #3;
        chk("rst.busy", 32'(busy0), 0);
        chk("rst.rdy", 32'(b0.in_ready), 0);
        chk("rst.vld", 32'(b0.out_valid), 0);
        res("rst", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        step;

        // basic window: hd 2+3+2+3=10, hw 2+1+3+0=6, narrow instance saturates hd at 7
        go;
        chk("prime.busy", 32'(busy0), 1);
        chk("prime.rdy", 32'(b0.in_ready), 1);
        send(3'b000);
        send(3'b101);
        send(3'b010);
        send(3'b111);
        b0.in_valid = 1'b1;
        b0.in_data  = 3'b000;
        chk("lat.pre", 32'(b0.out_valid), 0);
        step;
        b0.in_valid = 1'b0;
        chk("lat.post", 32'(b0.out_valid), 1);
        chk("rep.rdy", 32'(b0.in_ready), 0);
        res("basic", 10, 6, 7, 6, pk(3));
        hs;
        chk("idle.busy", 32'(busy0), 0);
        chk("idle.vld", 32'(b0.out_valid), 0);
        res("hold", 10, 6, 7, 6, pk(3));

        // stalls and backpressure
        go;
        send(3'b000);
        repeat (2) step;
        send(3'b101);
        repeat (2) step;
        send(3'b010);
        repeat (2) step;
        send(3'b111);
        repeat (2) step;
        send(3'b000);
        for (int i = 0; i < 5; i++) begin
            chk("bp.vld", 32'(b0.out_valid), 1);
            chk("bp.rdy", 32'(b0.in_ready), 0);
            chk("bp.hd0", 32'(b0.out_hd_sum), 10);
            step;
        end
        res("stall", 10, 6, 7, 6, pk(3));
        hs;
        chk("stall.idle", 32'(busy0), 0);

        // start held through PRIME and ACCUM, and in the handshake cycle
        go;
        start = 1'b1;
        send(3'b000);
        send(3'b101);
        send(3'b010);
        start = 1'b0;
        send(3'b111);
        send(3'b000);
        chk("st.vld", 32'(b0.out_valid), 1);
        res("start", 10, 6, 7, 6, pk(3));
        start = 1'b1;
        b0.out_ready = 1'b1;
        step;
        start = 1'b0;
        b0.out_ready = 1'b0;
        chk("st.hs_busy", 32'(busy0), 0);
        step;
        chk("st.after_busy", 32'(busy0), 0);
        chk("st.after_vld", 32'(b0.out_valid), 0);

        // abort after two ACCUM samples, with a sample offered in the abort cycle
        go;
        send(3'b000);
        send(3'b101);
        send(3'b010);
        abort = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_data  = 3'b111;
        step;
        abort = 1'b0;
        b0.in_valid = 1'b0;
        chk("ab.busy", 32'(busy0), 0);
        chk("ab.vld", 32'(b0.out_valid), 0);
        res("ab.clr", 0, 0, 0, 0, 0);
        repeat (3) step;
        chk("ab.novld", 32'(b0.out_valid), 0);
        go;
        repeat (5) send(3'b111);
        chk("ab2.vld", 32'(b0.out_valid), 1);
        res("abort", 0, 12, 0, 7, pk(0));
        hs;

        // saturation: every sample toggles all three bits
        go;
        send(3'b000);
        send(3'b111);
        send(3'b000);
        send(3'b111);
        send(3'b000);
        chk("sat.vld", 32'(b1.out_valid), 1);
        res("sat", 12, 6, 7, 6, pk(3));
        hs;

        // reset mid-ACCUM
        go;
        send(3'b000);
        send(3'b101);
        b0.in_valid = 1'b1;
        b0.in_data  = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        chk("mr.busy0", 32'(busy0), 0);
        chk("mr.busy1", 32'(busy1), 0);
        chk("mr.rdy", 32'(b0.in_ready), 0);
        chk("mr.vld", 32'(b0.out_valid), 0);
        res("mr", 0, 0, 0, 0, 0);
        repeat (2) begin
            step;
            b0.in_valid = ~b0.in_valid;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            b0.in_valid = ~b0.in_valid;
            chk("mr.post_vld", 32'(b0.out_valid), 0);
            chk("mr.post_busy", 32'(busy0), 0);
        end
        b0.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
